wb_slave_mem: RTL

- Wishbone classic-cycle slave memory that answers the CPU's wishbone master port.
- The CPU drives address, write data, write-enable, strobe, cycle and byte selects; this block returns read data and the acknowledge.
- Programmable wait states let the bench and the FPGA build emulate slow memory.
- Sits directly downstream of the CPU bus port, as the sole instruction/data store.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_slave_mem_if.sv | 25 ++
 rtl/wb_mem_array.sv | 23 ++
 rtl/wb_slave_mem.sv | 102 ++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone slave-memory types, bus widths and the byte-lane merge helper.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 16;
  localparam int unsigned WB_ADDR_W = 16;
  localparam int unsigned WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_t;

  // Lanes whose select bit is clear keep the old byte; only sel[1:0] map to the 16-bit word.
  function automatic logic [WB_DATA_W-1:0] byte_merge(
    input logic [WB_DATA_W-1:0] old_w,
    input logic [WB_DATA_W-1:0] new_w,
    input logic [1:0]           sel
  );
    logic [WB_DATA_W-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sel[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic-cycle bus between the CPU master port and the slave memory.
interface wb_slave_mem_if;
  import wb_pkg::*;

  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [WB_ADDR_W-1:0] adr_i;
  logic [WB_DATA_W-1:0] dat_i;
  logic [WB_SEL_W-1:0]  sel_i;
  logic [WB_DATA_W-1:0] dat_o;
  logic                 ack_o;
  logic                 err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_mem_array.sv
// Single-port synchronous RAM, 16-bit words, per-byte write enable, registered read.
module wb_mem_array
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WB_DATA_W-1:0]  wdata,
  input  logic [1:0]            be,
  output logic [WB_DATA_W-1:0]  rdata
);

  logic [WB_DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= byte_merge(mem[addr], wdata, be);
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave memory with programmable wait states and out-of-range error termination.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst,
  wb_slave_mem_if.slave  bus
);

  wb_state_t   state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        req;
  logic        in_range;
  logic        go_resp;
  logic        mem_we, mem_re;
  logic        ack_q, err_q, rd_q;
  logic [DATA_W-1:0] rdata;
  logic        unused_sel;

  assign req        = bus.cyc_i & bus.stb_i;
  assign in_range   = (bus.adr_i[ADDR_W-1:0] >> DEPTH_LOG2) == '0;
  assign unused_sel = ^bus.sel_i[3:2];

  // go_resp marks the edge entering RESP: the bus sample at that edge is what commits.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      go_resp   = 1'b0;
    end
  end

  assign mem_we = go_resp &  bus.we_i & in_range;
  assign mem_re = go_resp & ~bus.we_i & in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack_q <= go_resp &  in_range;
      err_q <= go_resp & ~in_range;
      rd_q  <= mem_re;
    end
  end

  wb_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (bus.adr_i[DEPTH_LOG2-1:0]),
    .wdata (bus.dat_i),
    .be    (bus.sel_i[1:0]),
    .rdata (rdata)
  );

  // RAM output register is not reset, so the read flag masks it to zero outside a read ack.
  assign bus.dat_o = rd_q ? rdata : '0;
  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;

endmodule
